// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - ID-stage control decoder and ID/EX control register with load-use and MUL stalls.
// Decode, hazard detection and the RUN/MUL_BUSY sequencer all live in this one module.

module control_pipe #(
  parameter int ALUOP_W = 2,
  parameter int MUL_LAT = 3,
  parameter int REG_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [6:0]         Op_i,
  input  logic [6:0]         Funct7_i,
  input  logic [REG_W-1:0]   Rs1_i,
  input  logic [REG_W-1:0]   Rs2_i,
  input  logic [REG_W-1:0]   Rd_i,
  input  logic               Valid_i,
  input  logic               Flush_i,
  input  logic               Stall_i,
  output logic               Branch_o,
  output logic               MemtoReg_o,
  output logic               MemWrite_o,
  output logic               MemRead_o,
  output logic               ALUSrc_o,
  output logic               RegWrite_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic [REG_W-1:0]   Rd_o,
  output logic               Valid_o,
  output logic               Stall_o,
  output logic               MulBusy_o
);

  localparam int CNT_W = $clog2(MUL_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               branch_q, branch_d;
  logic               memtoreg_q, memtoreg_d;
  logic               memwrite_q, memwrite_d;
  logic               memread_q, memread_d;
  logic               alusrc_q, alusrc_d;
  logic               regwrite_q, regwrite_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic               valid_q, valid_d;

  logic               dec_branch;
  logic               dec_memtoreg;
  logic               dec_memwrite;
  logic               dec_memread;
  logic               dec_alusrc;
  logic               dec_regwrite;
  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_is_mul;
  logic               load_use;

  always_comb begin
    dec_branch   = Op_i[6];
    dec_memtoreg = (Op_i[5:4] == 2'b00);
    dec_memread  = (Op_i[6:4] == 3'b000);
    dec_memwrite = (Op_i[6:4] == 3'b010);
    dec_alusrc   = (Op_i[5:4] != 2'b11);
    dec_regwrite = (Op_i[5:4] != 2'b10);
    dec_is_mul   = (Op_i == 7'b0110011) && (Funct7_i == 7'b0000001);
    dec_aluop    = '0;
    dec_aluop[1:0] = dec_is_mul ? 2'b11 : {(Op_i[5:4] == 2'b11), Op_i[6]};
  end

  // Only R/S/B-type (Op[5]=1) read rs2, so I-type rs2 bits never create a hazard.
  always_comb begin
    load_use = valid_q && memread_q && Valid_i && (rd_q != '0) &&
               ((rd_q == Rs1_i) || (Op_i[5] && (rd_q == Rs2_i)));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    branch_d   = branch_q;
    memtoreg_d = memtoreg_q;
    memwrite_d = memwrite_q;
    memread_d  = memread_q;
    alusrc_d   = alusrc_q;
    regwrite_d = regwrite_q;
    aluop_d    = aluop_q;
    rd_d       = rd_q;
    valid_d    = valid_q;

    if (Stall_i) begin
      state_d = state_q;
    end else if (state_q == MUL_BUSY) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = RUN;
      end
    end else if (Flush_i || !Valid_i || load_use) begin
      branch_d   = 1'b0;
      memtoreg_d = 1'b0;
      memwrite_d = 1'b0;
      memread_d  = 1'b0;
      alusrc_d   = 1'b0;
      regwrite_d = 1'b0;
      aluop_d    = '0;
      rd_d       = '0;
      valid_d    = 1'b0;
    end else begin
      branch_d   = dec_branch;
      memtoreg_d = dec_memtoreg;
      memwrite_d = dec_memwrite;
      memread_d  = dec_memread;
      alusrc_d   = dec_alusrc;
      regwrite_d = dec_regwrite;
      aluop_d    = dec_aluop;
      rd_d       = Rd_i;
      valid_d    = 1'b1;
      // A single-cycle MUL never needs the busy state.
      if (dec_is_mul && (MUL_LAT > 1)) begin
        state_d = MUL_BUSY;
        cnt_d   = CNT_LOAD;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      branch_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      aluop_q    <= '0;
      rd_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      branch_q   <= branch_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      memread_q  <= memread_d;
      alusrc_q   <= alusrc_d;
      regwrite_q <= regwrite_d;
      aluop_q    <= aluop_d;
      rd_q       <= rd_d;
      valid_q    <= valid_d;
    end
  end

  assign Branch_o   = branch_q;
  assign MemtoReg_o = memtoreg_q;
  assign MemWrite_o = memwrite_q;
  assign MemRead_o  = memread_q;
  assign ALUSrc_o   = alusrc_q;
  assign RegWrite_o = regwrite_q;
  assign ALUOp_o    = aluop_q;
  assign Rd_o       = rd_q;
  assign Valid_o    = valid_q;
  assign MulBusy_o  = (state_q == MUL_BUSY);
  assign Stall_o    = (state_q == MUL_BUSY) | (load_use & ~Flush_i);

endmodule
